// File: rtl/change_dispenser.sv
// Paced coin payout: turns a money amount into coin10/coin1 ejector pulses, tens first.
// Define COIN5_EN to add a coin5 output; at most one five is then paid between tens and ones.
module change_dispenser #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PULSE_TICKS = 2,
  parameter int unsigned GAP_TICKS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] amount_i,
`ifdef COIN5_EN
  output logic             coin5_o,
`endif
  output logic             coin10_o,
  output logic             coin1_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] remaining_o
);

  localparam int unsigned MaxTicks = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
  localparam int unsigned CntW     = (MaxTicks < 2) ? 1 : $clog2(MaxTicks + 1);

  localparam logic [WIDTH-1:0] Ten  = WIDTH'(10);
  localparam logic [WIDTH-1:0] One  = WIDTH'(1);
  localparam logic [CntW-1:0]  PulseLast = CntW'(PULSE_TICKS - 1);
  localparam logic [CntW-1:0]  GapLast   = CntW'(GAP_TICKS - 1);

  typedef enum logic [2:0] {StIdle, StSelect, StPulse, StGap, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             coin10_q, coin10_d;
  logic             coin1_q, coin1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef COIN5_EN
  localparam logic [WIDTH-1:0] Five = WIDTH'(5);
  logic             coin5_q, coin5_d;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cnt_d       = cnt_q;
    coin10_d    = coin10_q;
    coin1_d     = coin1_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef COIN5_EN
    coin5_d     = coin5_q;
`endif
    // Abort outranks every other event once a payout is underway, including ticks.
    if (abort_i && (state_q != StIdle)) begin
      state_d  = StIdle;
      cnt_d    = '0;
      coin10_d = 1'b0;
      coin1_d  = 1'b0;
      busy_d   = 1'b0;
`ifdef COIN5_EN
      coin5_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i && !abort_i) begin
            remaining_d = amount_i;
            busy_d      = 1'b1;
            state_d     = StSelect;
          end
        end
        StSelect: begin
          if (remaining_q >= Ten) begin
            remaining_d = remaining_q - Ten;
            coin10_d    = 1'b1;
            state_d     = StPulse;
`ifdef COIN5_EN
          end else if (remaining_q >= Five) begin
            remaining_d = remaining_q - Five;
            coin5_d     = 1'b1;
            state_d     = StPulse;
`endif
          end else if (remaining_q >= One) begin
            remaining_d = remaining_q - One;
            coin1_d     = 1'b1;
            state_d     = StPulse;
          end else begin
            state_d = StDone;
          end
        end
        StPulse: begin
          if (tick_i) begin
            if (cnt_q == PulseLast) begin
              cnt_d    = '0;
              coin10_d = 1'b0;
              coin1_d  = 1'b0;
`ifdef COIN5_EN
              coin5_d  = 1'b0;
`endif
              state_d  = StGap;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StGap: begin
          if (tick_i) begin
            if (cnt_q == GapLast) begin
              cnt_d   = '0;
              state_d = StSelect;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StDone: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      cnt_q       <= '0;
      coin10_q    <= 1'b0;
      coin1_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef COIN5_EN
      coin5_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      coin10_q    <= coin10_d;
      coin1_q     <= coin1_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef COIN5_EN
      coin5_q     <= coin5_d;
`endif
    end
  end

  assign coin10_o    = coin10_q;
  assign coin1_o     = coin1_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign remaining_o = remaining_q;
`ifdef COIN5_EN
  assign coin5_o     = coin5_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected coin sequence queued at start, checked per pulse.
module tb_change_dispenser;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned PulseTicks = 2;
  localparam int unsigned GapTicks = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_i = 1'b0;
  logic start_i = 1'b0;
  logic abort_i = 1'b0;
  logic [WIDTH-1:0] amount_i = '0;
  logic coin10_o, coin1_o, coin5_w, busy_o, done_o;
  logic [WIDTH-1:0] remaining_o;

  change_dispenser #(
    .WIDTH      (WIDTH),
    .PULSE_TICKS(PulseTicks),
    .GAP_TICKS  (GapTicks)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_i     (tick_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .amount_i   (amount_i),
`ifdef COIN5_EN
    .coin5_o    (coin5_w),
`endif
    .coin10_o   (coin10_o),
    .coin1_o    (coin1_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .remaining_o(remaining_o)
  );
`ifndef COIN5_EN
  assign coin5_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       coins;  // {coin10, coin5, coin1}
    logic [WIDTH-1:0] rem;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int ten_falls = 0;
  bit mon_en = 1'b0;
  bit seen99 = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void push_payout(input int n);
    int r = n;
    exp_t e;
    while (r >= 10) begin
      r -= 10; e.coins = 3'b100; e.rem = WIDTH'(r); sb.push_back(e);
    end
`ifdef COIN5_EN
    if (r >= 5) begin
      r -= 5; e.coins = 3'b010; e.rem = WIDTH'(r); sb.push_back(e);
    end
`endif
    while (r >= 1) begin
      r -= 1; e.coins = 3'b001; e.rem = WIDTH'(r); sb.push_back(e);
    end
  endfunction

  // Free-running pacing strobe: one clk high in every four.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 tick_i = 1'b1;
      @(posedge clk);
      #1 tick_i = 1'b0;
    end
  end

  // Monitor: pulse shape, gap length, scoreboard pops on each rising coin.
  logic [2:0] prev_c = '0;
  int pt = 0, gt = 0;
  bit gap_act = 1'b0;
  always @(negedge clk) begin
    logic [2:0] cur;
    exp_t e;
    cur = {coin10_o, coin5_w, coin1_o};
    if (mon_en) begin
      if (done_o) begin
        done_cnt++;
        check_eq("busy_with_done", 32'(busy_o), 0);
      end
      if (remaining_o == WIDTH'(99)) seen99 = 1'b1;
      if (cur != 0 && prev_c == 0) begin
        check_eq("onehot", $countones(cur), 1);
        if (gap_act) check_eq("gap_ticks", gt, GapTicks);
        gap_act = 1'b0;
        pt = tick_i ? 1 : 0;
        if (sb.size() == 0) begin
          check_eq("unexpected_coin", 32'(cur), 0);
        end else begin
          e = sb.pop_front();
          check_eq("coin_kind", 32'(cur), 32'(e.coins));
          check_eq("coin_rem", 32'(remaining_o), 32'(e.rem));
        end
      end else if (cur != 0) begin
        check_eq("coin_stable", 32'(cur), 32'(prev_c));
        if (tick_i) pt++;
      end else if (prev_c != 0) begin
        check_eq("pulse_ticks", pt, PulseTicks);
        if (prev_c[2]) ten_falls++;
        gap_act = 1'b1;
        gt = tick_i ? 1 : 0;
      end else if (gap_act && tick_i) begin
        gt++;
      end
      if (!busy_o) gap_act = 1'b0;
    end
    prev_c = cur;
  end

  task automatic drive_start(input int a);
    @(posedge clk);
    #1 amount_i = WIDTH'(a); start_i = 1'b1;
    push_payout(a);
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done_o && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq({tag, "_done_seen"}, 32'(done_o), 1);
  endtask

  task automatic finish_payout(input string tag);
    int d0 = done_cnt;
    wait_done(tag);
    check_eq({tag, "_busy"}, 32'(busy_o), 0);
    check_eq({tag, "_rem"}, 32'(remaining_o), 0);
    check_eq({tag, "_sb_empty"}, sb.size(), 0);
    repeat (3) @(posedge clk);
    #1 check_eq({tag, "_done_once"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0, k;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_coin10", 32'(coin10_o), 0);
    check_eq("rst_coin1", 32'(coin1_o), 0);
    check_eq("rst_busy", 32'(busy_o), 0);
    check_eq("rst_done", 32'(done_o), 0);
    check_eq("rst_rem", 32'(remaining_o), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // 23 -> two tens, three ones
    drive_start(23);
    check_eq("p23_busy", 32'(busy_o), 1);
    finish_payout("p23");

    // zero amount: done exactly two clks after start
    drive_start(0);
    check_eq("z_busy0", 32'(busy_o), 1);
    check_eq("z_done0", 32'(done_o), 0);
    @(posedge clk); #1;
    check_eq("z_busy1", 32'(busy_o), 1);
    check_eq("z_done1", 32'(done_o), 0);
    @(posedge clk); #1;
    check_eq("z_done2", 32'(done_o), 1);
    check_eq("z_busy2", 32'(busy_o), 0);
    @(posedge clk); #1;
    check_eq("z_done3", 32'(done_o), 0);

    // 15 with an ignored restart of 99 during the first tens pulse
    seen99 = 1'b0;
    drive_start(15);
    k = 0;
    while (!coin10_o && k < 200) begin @(posedge clk); #1; k++; end
    check_eq("r15_coin10_up", 32'(coin10_o), 1);
    amount_i = WIDTH'(99); start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    check_eq("r15_rem_held", 32'(remaining_o), 5);
    finish_payout("r15");
    check_eq("r15_no99", 32'(seen99), 0);

    // 37 aborted in the gap after the second ten
    ten_falls = 0;
    drive_start(37);
    k = 0;
    while (ten_falls < 2 && k < 500) begin @(posedge clk); #1; k++; end
    check_eq("ab_in_gap", 32'(coin10_o | coin1_o), 0);
    d0 = done_cnt;
    abort_i = 1'b1;
    @(posedge clk); #1 abort_i = 1'b0;
    check_eq("ab_coins", 32'({coin10_o, coin5_w, coin1_o}), 0);
    check_eq("ab_busy", 32'(busy_o), 0);
    check_eq("ab_rem", 32'(remaining_o), 17);
    sb.delete();
    repeat (30) @(posedge clk);
    #1 check_eq("ab_no_done", done_cnt - d0, 0);
    check_eq("ab_rem_hold", 32'(remaining_o), 17);
    drive_start(4);
    finish_payout("ab4");

    // 27: tens, then (with coin5) a five, then ones
    drive_start(27);
    finish_payout("p27");

    // asynchronous reset mid tens pulse
    drive_start(50);
    k = 0;
    while (!coin10_o && k < 200) begin @(posedge clk); #1; k++; end
    check_eq("ar_coin10_up", 32'(coin10_o), 1);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("ar_coin10", 32'(coin10_o), 0);
    check_eq("ar_busy", 32'(busy_o), 0);
    check_eq("ar_done", 32'(done_o), 0);
    check_eq("ar_rem", 32'(remaining_o), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("ar_idle_coins", 32'({coin10_o, coin5_w, coin1_o}), 0);
    check_eq("ar_idle_busy", 32'(busy_o), 0);
    check_eq("ar_idle_done", 32'(done_o), 0);
    check_eq("ar_idle_rem", 32'(remaining_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
